// File: rtl/n8_controller_reader.sv
// N8 controller reader: polls the pad with a latch/clock/data transaction and
// publishes a registered, active-high button word plus exclusive left/right levels.
module n8_controller_reader #(
  parameter int CLK_DIV     = 300,
  parameter int POLL_PERIOD = 833_333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_data,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic [7:0] buttons,
  output logic       left,
  output logic       right,
  output logic       valid
);

  localparam int PW  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int PHW = $clog2(2 * CLK_DIV);

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  typedef struct packed {
    logic [7:0] buttons;
    logic       left;
    logic       right;
  } report_t;

  state_t         state;
  logic [PW-1:0]  poll_cnt;
  logic [PHW-1:0] phase;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic [7:0]     sample_word;
  logic [1:0]     sync_ff;
  logic           sync_data;
  logic           wrap;
  logic           last_latch;
  logic           last_half;
  report_t        rpt;

  assign sync_data  = sync_ff[1];
  assign wrap       = (poll_cnt == PW'(POLL_PERIOD - 1));
  assign last_latch = (phase == PHW'(2 * CLK_DIV - 1));
  assign last_half  = (phase == PHW'(CLK_DIV - 1));

  assign buttons = rpt.buttons;
  assign left    = rpt.left;
  assign right   = rpt.right;

  // Resets to "not pressed" so a floating/absent pad never reads as pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_ff <= 2'b11;
    else       sync_ff <= {sync_ff[0], ctrl_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     poll_cnt <= '0;
    else if (wrap) poll_cnt <= '0;
    else           poll_cnt <= poll_cnt + PW'(1);
  end

  // Shift word with the bit being sampled this cycle already merged in.
  always_comb begin
    sample_word          = shift;
    sample_word[bit_idx] = ~sync_data;
  end

  // Outputs are assigned alongside the state transition so that they track
  // the state they decode; the final word and valid land on entry to DONE,
  // making valid high for exactly the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rpt        <= '0;
      valid      <= 1'b0;
      ctrl_latch <= 1'b0;
      ctrl_clk   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          phase <= '0;
          if (wrap) begin
            state      <= LATCH;
            ctrl_latch <= 1'b1;
          end
        end
        LATCH: begin
          if (last_latch) begin
            phase      <= '0;
            bit_idx    <= '0;
            state      <= LOW;
            ctrl_latch <= 1'b0;
          end else begin
            phase <= phase + PHW'(1);
          end
        end
        LOW: begin
          if (last_half) begin
            phase <= '0;
            shift <= sample_word;
            if (bit_idx == 3'd7) begin
              state       <= DONE;
              rpt.buttons <= sample_word;
              rpt.left    <= sample_word[6] & ~sample_word[7];
              rpt.right   <= sample_word[7] & ~sample_word[6];
              valid       <= 1'b1;
            end else begin
              state    <= HIGH;
              ctrl_clk <= 1'b1;
            end
          end else begin
            phase <= phase + PHW'(1);
          end
        end
        HIGH: begin
          if (last_half) begin
            phase    <= '0;
            bit_idx  <= bit_idx + 3'd1;
            state    <= LOW;
            ctrl_clk <= 1'b0;
          end else begin
            phase <= phase + PHW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          ctrl_latch <= 1'b0;
          ctrl_clk   <= 1'b0;
        end
      endcase
    end
  end

endmodule
